// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control unit: sequences fetch/decode/execute/memory/writeback
// for a shared-memory datapath and counts retired instructions.
module mc_ctrl_fsm #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             iord,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             ir_we,
  output logic             reg_we,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_ctrl,
  output logic [3:0]       state,
  output logic             retire,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [3:0] {
    S_IF    = 4'd0,  S_ID    = 4'd1,  S_MA   = 4'd2,  S_LW_RD = 4'd3,
    S_LW_WB = 4'd4,  S_SW    = 4'd5,  S_R_EX = 4'd6,  S_R_WB  = 4'd7,
    S_BR    = 4'd8,  S_J     = 4'd9,  S_I_EX = 4'd10, S_I_WB  = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t           state_r, next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       r_alu_s;
  logic             r_legal_s;
  logic             pc_we_s, iord_s, mem_rd_s, mem_wr_s, ir_we_s, reg_we_s;
  logic             reg_dst_s, mem_to_reg_s, alu_src_a_s, retire_s;
  logic [1:0]       pc_src_s, alu_src_b_s;
  logic [2:0]       alu_ctrl_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= S_IF;
    else     state_r <= next_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           cnt_r <= '0;
    else if (retire_s) cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    else               cnt_r <= cnt_r;
  end

  always_comb begin
    r_alu_s   = ALU_AND;
    r_legal_s = 1'b1;
    case (funct)
      6'b100000: r_alu_s = ALU_ADD;
      6'b100010: r_alu_s = ALU_SUB;
      6'b100100: r_alu_s = ALU_AND;
      6'b100101: r_alu_s = ALU_OR;
      6'b101010: r_alu_s = ALU_SLT;
      default: begin
        r_alu_s   = ALU_AND;
        r_legal_s = 1'b0;
      end
    endcase
  end

  always_comb begin
    next_s       = S_IF;
    pc_we_s      = 1'b0;
    pc_src_s     = 2'b00;
    iord_s       = 1'b0;
    mem_rd_s     = 1'b0;
    mem_wr_s     = 1'b0;
    ir_we_s      = 1'b0;
    reg_we_s     = 1'b0;
    reg_dst_s    = 1'b0;
    mem_to_reg_s = 1'b0;
    alu_src_a_s  = 1'b0;
    alu_src_b_s  = 2'b00;
    alu_ctrl_s   = 3'b000;
    retire_s     = 1'b0;
    case (state_r)
      S_IF: begin
        mem_rd_s    = 1'b1;
        alu_src_b_s = 2'b01;
        alu_ctrl_s  = ALU_ADD;
        ir_we_s     = mem_ready;
        pc_we_s     = mem_ready;
        if (mem_ready) next_s = S_ID;
        else           next_s = S_IF;
      end
      S_ID: begin
        alu_src_b_s = 2'b11;
        alu_ctrl_s  = ALU_ADD;
        case (opcode)
          OP_LW, OP_SW:   next_s = S_MA;
          OP_RTYPE:       next_s = S_R_EX;
          OP_BEQ, OP_BNE: next_s = S_BR;
          OP_J:           next_s = S_J;
          OP_ADDI:        next_s = S_I_EX;
          default:        next_s = S_IF;
        endcase
      end
      S_MA: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'b10;
        alu_ctrl_s  = ALU_ADD;
        if (opcode == OP_LW)      next_s = S_LW_RD;
        else if (opcode == OP_SW) next_s = S_SW;
        else                      next_s = S_IF;
      end
      S_LW_RD: begin
        mem_rd_s = 1'b1;
        iord_s   = 1'b1;
        if (mem_ready) next_s = S_LW_WB;
        else           next_s = S_LW_RD;
      end
      S_LW_WB: begin
        reg_we_s     = 1'b1;
        mem_to_reg_s = 1'b1;
        retire_s     = 1'b1;
      end
      S_SW: begin
        mem_wr_s = 1'b1;
        iord_s   = 1'b1;
        retire_s = mem_ready;
        if (mem_ready) next_s = S_IF;
        else           next_s = S_SW;
      end
      S_R_EX: begin
        alu_src_a_s = 1'b1;
        alu_ctrl_s  = r_alu_s;
        if (r_legal_s) next_s = S_R_WB;
        else           next_s = S_IF;
      end
      S_R_WB: begin
        alu_src_a_s = 1'b1;
        alu_ctrl_s  = r_alu_s;
        reg_we_s    = 1'b1;
        reg_dst_s   = 1'b1;
        retire_s    = 1'b1;
      end
      S_BR: begin
        // Branch target was parked in ALUOut during decode
        alu_src_a_s = 1'b1;
        alu_ctrl_s  = ALU_SUB;
        pc_src_s    = 2'b01;
        pc_we_s     = (opcode == OP_BEQ) ? zero : ~zero;
        retire_s    = 1'b1;
      end
      S_J: begin
        pc_src_s = 2'b10;
        pc_we_s  = 1'b1;
        retire_s = 1'b1;
      end
      S_I_EX: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'b10;
        alu_ctrl_s  = ALU_ADD;
        next_s      = S_I_WB;
      end
      S_I_WB: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'b10;
        alu_ctrl_s  = ALU_ADD;
        reg_we_s    = 1'b1;
        retire_s    = 1'b1;
      end
      default: next_s = S_IF;
    endcase
  end

  // Reset masks every strobe and select immediately, even mid memory wait
  assign pc_we      = pc_we_s & ~rst;
  assign pc_src     = rst ? 2'b00 : pc_src_s;
  assign iord       = iord_s & ~rst;
  assign mem_rd     = mem_rd_s & ~rst;
  assign mem_wr     = mem_wr_s & ~rst;
  assign ir_we      = ir_we_s & ~rst;
  assign reg_we     = reg_we_s & ~rst;
  assign reg_dst    = reg_dst_s & ~rst;
  assign mem_to_reg = mem_to_reg_s & ~rst;
  assign alu_src_a  = alu_src_a_s & ~rst;
  assign alu_src_b  = rst ? 2'b00 : alu_src_b_s;
  assign alu_ctrl   = rst ? 3'b000 : alu_ctrl_s;
  assign retire     = retire_s & ~rst;
  assign state      = state_r;
  assign instr_cnt  = cnt_r;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: a reference sequence model pushes per-cycle
// expectations, and the driver pops one per cycle and compares.
module tb_mc_ctrl_fsm;

  localparam int CW = 4;
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, JMP = 6'b000010, ADDI = 6'b001000;

  logic clk = 1'b0, rst = 1'b1;
  logic [5:0] opcode = 6'd0, funct = 6'd0;
  logic zero = 1'b0, mem_ready = 1'b0;
  logic pc_we, iord, mem_rd, mem_wr, ir_we, reg_we, reg_dst, mem_to_reg, alu_src_a, retire;
  logic [1:0] pc_src, alu_src_b;
  logic [2:0] alu_ctrl;
  logic [3:0] state;
  logic [CW-1:0] instr_cnt;

  mc_ctrl_fsm #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_we(pc_we), .pc_src(pc_src), .iord(iord), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .ir_we(ir_we), .reg_we(reg_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .state(state),
    .retire(retire), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]    op, fn;
    logic          z, mr;
    logic [3:0]    st;
    logic [16:0]   sg;
    logic [CW-1:0] cnt;
  } rec_t;

  rec_t sb[$];
  logic [CW-1:0] exp_cnt = '0;
  int checks = 0, passed = 0;
  logic [16:0] dut_sig;

  assign dut_sig = {pc_we, ir_we, mem_rd, mem_wr, iord, reg_we, reg_dst, mem_to_reg, retire,
                    alu_src_a, alu_src_b, pc_src, alu_ctrl};

  function automatic logic [16:0] sg(input logic pcw, irw, mrd, mwr, io, rw, rd, m2r, ret, asa,
                                     input logic [1:0] asb, pcs, input logic [2:0] alu);
    return {pcw, irw, mrd, mwr, io, rw, rd, m2r, ret, asa, asb, pcs, alu};
  endfunction

  task automatic push(input logic [5:0] op, fn, input logic z, mr, input logic [3:0] st,
                      input logic [16:0] s);
    rec_t r;
    r.op = op; r.fn = fn; r.z = z; r.mr = mr; r.st = st; r.sg = s; r.cnt = exp_cnt;
    sb.push_back(r);
    if (s[8]) exp_cnt = exp_cnt + 1'b1;
  endtask

  // Reference sequence of one instruction, with fetch and data-memory wait cycles
  task automatic model_instr(input logic [5:0] op, fn, input logic z, input int if_wait, mem_wait);
    logic [2:0] alu;
    logic legal, pcw, dc;
    dc = 1'($urandom_range(0, 1));
    for (int i = 0; i < if_wait; i++)
      push(op, fn, z, 1'b0, 4'd0, sg(0,0,1,0,0,0,0,0,0,0,2'b01,2'b00,3'b010));
    push(op, fn, z, 1'b1, 4'd0, sg(1,1,1,0,0,0,0,0,0,0,2'b01,2'b00,3'b010));
    push(op, fn, z, dc, 4'd1, sg(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010));
    if (op == LW || op == SW)
      push(op, fn, z, dc, 4'd2, sg(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010));
    if (op == LW) begin
      for (int i = 0; i < mem_wait; i++)
        push(op, fn, z, 1'b0, 4'd3, sg(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,3'b000));
      push(op, fn, z, 1'b1, 4'd3, sg(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,3'b000));
      push(op, fn, z, dc, 4'd4, sg(0,0,0,0,0,1,0,1,1,0,2'b00,2'b00,3'b000));
    end else if (op == SW) begin
      for (int i = 0; i < mem_wait; i++)
        push(op, fn, z, 1'b0, 4'd5, sg(0,0,0,1,1,0,0,0,0,0,2'b00,2'b00,3'b000));
      push(op, fn, z, 1'b1, 4'd5, sg(0,0,0,1,1,0,0,0,1,0,2'b00,2'b00,3'b000));
    end else if (op == RT) begin
      legal = 1'b1;
      case (fn)
        6'b100000: alu = 3'b010;
        6'b100010: alu = 3'b110;
        6'b100100: alu = 3'b000;
        6'b100101: alu = 3'b001;
        6'b101010: alu = 3'b111;
        default: begin alu = 3'b000; legal = 1'b0; end
      endcase
      push(op, fn, z, dc, 4'd6, sg(0,0,0,0,0,0,0,0,0,1,2'b00,2'b00,alu));
      if (legal) push(op, fn, z, dc, 4'd7, sg(0,0,0,0,0,1,1,0,1,1,2'b00,2'b00,alu));
    end else if (op == BEQ || op == BNE) begin
      pcw = (op == BEQ) ? z : ~z;
      push(op, fn, z, dc, 4'd8, sg(pcw,0,0,0,0,0,0,0,1,1,2'b00,2'b01,3'b110));
    end else if (op == JMP) begin
      push(op, fn, z, dc, 4'd9, sg(1,0,0,0,0,0,0,0,1,0,2'b00,2'b10,3'b000));
    end else if (op == ADDI) begin
      push(op, fn, z, dc, 4'd10, sg(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010));
      push(op, fn, z, dc, 4'd11, sg(0,0,0,0,0,1,0,0,1,1,2'b10,2'b00,3'b010));
    end
  endtask

  // Pops up to n records, one per cycle: drive on negedge, compare 1 time unit later
  task automatic run(input int n);
    rec_t r;
    for (int k = 0; k < n && sb.size() > 0; k++) begin
      r = sb.pop_front();
      @(negedge clk);
      opcode = r.op; funct = r.fn; zero = r.z; mem_ready = r.mr;
      #1;
      checks++;
      if (state !== r.st) $display("FAIL state op=%b: got %0d want %0d", r.op, state, r.st);
      else passed++;
      checks++;
      if (dut_sig !== r.sg) $display("FAIL strobes op=%b st=%0d: got %b want %b", r.op, r.st, dut_sig, r.sg);
      else passed++;
      checks++;
      if (instr_cnt !== r.cnt) $display("FAIL instr_cnt st=%0d: got %0d want %0d", r.st, instr_cnt, r.cnt);
      else passed++;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1; mem_ready = 1'b1; opcode = LW;
    #1;
    checks++;
    if (state !== 4'd0 || dut_sig !== 17'd0 || instr_cnt !== '0)
      $display("FAIL reset: state=%0d sig=%b cnt=%0d want 0/0/0", state, dut_sig, instr_cnt);
    else passed++;
    @(negedge clk);
    rst = 1'b0; mem_ready = 1'b0;
    exp_cnt = '0;
  endtask

  task automatic test_rtype;
    model_instr(RT, 6'b100000, 1'b0, 0, 0);
    run(sb.size());
  endtask

  task automatic test_lw_wait;
    model_instr(LW, 6'd0, 1'b0, 0, 3);
    model_instr(SW, 6'd0, 1'b0, 1, 2);
    model_instr(SW, 6'd0, 1'b0, 0, 0);
    run(sb.size());
  endtask

  task automatic test_branch;
    model_instr(BEQ, 6'd0, 1'b1, 0, 0);
    model_instr(BEQ, 6'd0, 1'b0, 0, 0);
    model_instr(BNE, 6'd0, 1'b0, 0, 0);
    model_instr(BNE, 6'd0, 1'b1, 0, 0);
    run(sb.size());
  endtask

  task automatic test_illegal;
    model_instr(6'b111111, 6'd0, 1'b0, 0, 0);
    model_instr(RT, 6'b000111, 1'b0, 0, 0);
    run(sb.size());
  endtask

  task automatic test_back_to_back;
    model_instr(ADDI, 6'd0, 1'b0, 2, 0);
    model_instr(RT, 6'b100010, 1'b0, 0, 0);
    model_instr(RT, 6'b100100, 1'b0, 1, 0);
    model_instr(RT, 6'b100101, 1'b0, 0, 0);
    model_instr(RT, 6'b101010, 1'b0, 0, 0);
    model_instr(LW, 6'd0, 1'b0, 0, 0);
    run(sb.size());
  endtask

  task automatic test_reset_in_sw;
    model_instr(SW, 6'd0, 1'b0, 0, 6);
    run(5);
    sb.delete();
    checks++;
    if (mem_wr !== 1'b1 || state !== 4'd5)
      $display("FAIL sw_wait: mem_wr=%b state=%0d want 1/5", mem_wr, state);
    else passed++;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (mem_wr !== 1'b0 || state !== 4'd0 || instr_cnt !== '0)
      $display("FAIL async_reset: mem_wr=%b state=%0d cnt=%0d want 0/0/0", mem_wr, state, instr_cnt);
    else passed++;
    @(negedge clk);
    rst = 1'b0; mem_ready = 1'b0;
    exp_cnt = '0;
    model_instr(JMP, 6'd0, 1'b0, 0, 0);
    run(sb.size());
  endtask

  task automatic test_jump_wrap;
    test_reset();
    for (int i = 0; i < 17; i++) model_instr(JMP, 6'd0, 1'b0, 0, 0);
    run(sb.size());
    @(negedge clk);
    #1;
    checks++;
    if (instr_cnt !== 4'd1) $display("FAIL wrap_final: got %0d want 1", instr_cnt);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_branch();
    test_illegal();
    test_back_to_back();
    test_reset_in_sw();
    test_jump_wrap();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Multi-cycle MIPS control unit. It sequences the shared datapath (one memory, one ALU, PC, IR, register file) through fetch, decode, execute, memory and writeback states. It decodes opcode/funct from the IR, drives all datapath strobes and muxes, waits on a memory-ready handshake, and counts retired instructions for the debug display.

Parameters:
CNT_W, 16, width of retired-instruction counter instr_cnt

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes current access this cycle
pc_we  out  1  PC write enable
pc_src  out  2  00 ALU result, 01 ALUOut reg, 10 jump target
iord  out  1  mem address: 0 PC, 1 ALUOut
mem_rd  out  1  memory read request
mem_wr  out  1  memory write request
ir_we  out  1  IR load
reg_we  out  1  register file write
reg_dst  out  1  0 rt, 1 rd
mem_to_reg  out  1  0 ALUOut, 1 MDR
alu_src_a  out  1  0 PC, 1 reg A
alu_src_b  out  2  00 reg B, 01 const 4, 10 signext imm, 11 signext imm<<2
alu_ctrl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
state  out  4  current state, debug
retire  out  1  one-cycle pulse on instruction completion
instr_cnt  out  CNT_W  retired instructions, wraps

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous, active-high. While rst=1: state=IF (0), instr_cnt=0, every strobe (pc_we, ir_we, mem_rd, mem_wr, reg_we, retire) forced to 0, and every mux select and alu_ctrl is 0.
- Outputs are Moore decodes of state. Exceptions: pc_we, ir_we and retire may also depend on mem_ready or zero (combinational, same cycle).
- States and encodings: IF=0, ID=1, MA=2, LW_RD=3, LW_WB=4, SW=5, R_EX=6, R_WB=7, BR=8, J=9, I_EX=10, I_WB=11. Codes 12-15 are illegal and go to IF on the next cycle, with no strobes.
- IF: mem_rd=1, iord=0, alu_src_a=0, alu_src_b=01, add, pc_src=00; ir_we=pc_we=mem_ready. Holds in IF while mem_ready=0; goes to ID when mem_ready=1.
- ID: alu_src_a=0, alu_src_b=11, add (branch target into ALUOut). Next state by opcode:
  - 100011 (lw) or 101011 (sw) -> MA
  - 000000 -> R_EX
  - 000100 (beq) or 000101 (bne) -> BR
  - 000010 (j) -> J
  - 001000 (addi) -> I_EX
  - any other opcode -> IF, not retired
- MA: alu_src_a=1, alu_src_b=10, add. Next LW_RD for lw, SW for sw.
- LW_RD: mem_rd=1, iord=1. Holds until mem_ready, then LW_WB.
- LW_WB: reg_we=1, reg_dst=0, mem_to_reg=1, retire. Next IF.
- SW: mem_wr=1, iord=1. Holds until mem_ready. On the ready cycle: retire, next IF.
- R_EX: alu_src_a=1, alu_src_b=00. alu_ctrl from funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt. Legal funct -> R_WB; unknown funct -> IF, not retired.
- R_WB: holds R_EX ALU controls; reg_we=1, reg_dst=1, mem_to_reg=0, retire. Next IF.
- BR: alu_src_a=1, alu_src_b=00, sub, pc_src=01. pc_we = zero for beq, ~zero for bne. Retire; next IF.
- J: pc_src=10, pc_we=1, retire. Next IF.
- I_EX: alu_src_a=1, alu_src_b=10, add. Next I_WB.
- I_WB: holds I_EX ALU controls; reg_we=1, reg_dst=0, mem_to_reg=0, retire. Next IF.
- Latency without wait states (mem_ready tied 1): R/addi 4 cycles, lw 5, sw 4, beq/bne 3, j 3.
- mem_rd and mem_wr are never asserted together.
- mem_rd/mem_wr stay asserted for the whole wait, with address selects stable.
- instr_cnt increments on the cycle retire=1 and wraps from 2^CNT_W-1 to 0.
- Reset asserted mid-instruction (including during a memory wait) aborts immediately: state returns to IF, no pending write completes, and the count is kept at 0.

Test Plan:
- Reset, then mem_ready=1, opcode=000000, funct=100000 -> state sequence 0,1,6,7,0; reg_we=1 and reg_dst=1 only in state 7; retire once; instr_cnt=1.
- lw (100011) with mem_ready low 3 cycles in LW_RD -> state held at 3 for 3 cycles with mem_rd=1, iord=1; then 4, then 0; reg_we and mem_to_reg both 1 in state 4; total 8 cycles.
- beq with zero=1, then beq with zero=0 -> pc_we=1, pc_src=01 in BR for the first and pc_we=0 for the second; bne with zero=0 -> pc_we=1; each takes 3 cycles and retires.
- Opcode 111111, then R-type with funct 000111 -> both return to IF without reg_we or retire; instr_cnt unchanged.
- rst pulsed while in SW waiting on mem_ready=0 -> mem_wr drops asynchronously, state=0, instr_cnt=0; fetch resumes after release.
- CNT_W=4, 17 j instructions -> instr_cnt wraps 15 -> 0 and ends at 1; j shows pc_src=10, pc_we=1 in state 9.
